// File: rtl/btn_inport_if.sv
`default_nettype none
// ============================================================================
// btn_inport_if : button inport bus between processor (master) and btn_inport
// Revision      : 1.0
// ============================================================================
interface btn_inport_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0]   btn;
    logic               rd_en;
    logic [2*N_BTN-1:0] inport;
    logic               irq;
    logic               ovr;

    modport master (
        output btn,
        output rd_en,
        input  inport,
        input  irq,
        input  ovr
    );

    modport slave (
        input  btn,
        input  rd_en,
        output inport,
        output irq,
        output ovr
    );
endinterface
`default_nettype wire

// File: rtl/btn_inport.sv
`default_nettype none
// ============================================================================
// btn_inport : per-button sync, debounce, press detect and sticky pending flags
// Revision   : 1.0
// ============================================================================
module btn_inport #(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = 1000000
) (
    input  wire logic   clk_i,
    input  wire logic   rst_ni,
    btn_inport_if.slave bus
);
    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] pend_q;
    logic [N_BTN-1:0] pend_d;
    logic [N_BTN-1:0] press;
    logic             ovr_q;
    logic             ovr_d;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_bit
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          lvl_nxt;

            // Counter is zero while s2 agrees with level; any agreement restarts the count.
            always_comb begin
                cnt_d   = '0;
                lvl_nxt = level_q[gi];
                if (s2_q[gi] != level_q[gi]) begin
                    if (cnt_q == CNT_LAST) begin
                        lvl_nxt = s2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            assign level_d[gi] = lvl_nxt;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign press = level_d & ~level_q;

    // A press landing with rd_en still wins; overrun only counts presses not being read.
    always_comb begin
        pend_d = (bus.rd_en ? '0 : pend_q) | press;
        ovr_d  = (bus.rd_en ? 1'b0 : ovr_q) | (!bus.rd_en && (|(press & pend_q)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pend_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= bus.btn;
            s2_q    <= s1_q;
            level_q <= level_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.inport = {level_q, pend_q};
    assign bus.irq    = |pend_q;
    assign bus.ovr    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_inport.sv
`default_nettype none
// ============================================================================
// tb_btn_inport : directed plan plus randomized stimulus against a window model
// Revision      : 1.0
// ============================================================================
module tb_btn_inport;
    localparam int N  = 4;
    localparam int DB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    btn_inport_if #(.N_BTN(N)) bus();

    btn_inport #(
        .N_BTN     (N),
        .DB_CYCLES (DB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] m_lev;
    logic [N-1:0] m_pend;
    logic         m_ovr;
    // hist[0] is the pin value presented at the current edge, hist[k] k edges earlier.
    logic [N-1:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_lev  = '0;
        m_pend = '0;
        m_ovr  = 1'b0;
        hist.delete();
        for (int k = 0; k < DB + 2; k++) hist.push_back('0);
    endfunction

    // Level flips once the debouncer has seen DB consecutive synchronised samples
    // that all differ from it; the synchroniser delays each pin sample by two edges.
    function automatic void model_edge(input logic [N-1:0] b, input logic rd);
        logic [N-1:0] nl;
        logic [N-1:0] press;
        logic [N-1:0] hv;
        bit           all_diff;
        hist.push_front(b);
        void'(hist.pop_back());
        nl = m_lev;
        for (int i = 0; i < N; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k < DB + 2; k++) begin
                hv = hist[k];
                if (hv[i] == m_lev[i]) all_diff = 1'b0;
            end
            if (all_diff) nl[i] = ~m_lev[i];
        end
        press = nl & ~m_lev;
        if (!rd && ((press & m_pend) != '0)) m_ovr = 1'b1;
        else if (rd) m_ovr = 1'b0;
        m_pend = (rd ? '0 : m_pend) | press;
        m_lev  = nl;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".inport"}, 32'(bus.inport), 32'({m_lev, m_pend}));
        chk({tag, ".irq"},    32'(bus.irq),    32'(|m_pend));
        chk({tag, ".ovr"},    32'(bus.ovr),    32'(m_ovr));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic tick(input logic [N-1:0] b, input logic rd);
        bus.btn   = b;
        bus.rd_en = rd;
        if (rst_n) model_edge(b, rd);
        else       model_clear();
        @(posedge clk);
        #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    task automatic ticks(input logic [N-1:0] b, input int n);
        for (int c = 0; c < n; c++) tick(b, 1'b0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst.inport", 32'(bus.inport), 32'h0);
        chk("rst.irq",    32'(bus.irq),    32'h0);
        chk("rst.ovr",    32'(bus.ovr),    32'h0);
    endtask

    initial begin
        bus.btn   = '1;
        bus.rd_en = 1'b0;
        model_clear();
        @(negedge clk);

        // Reset with all buttons held high, then release.
        assert_reset();
        ticks(4'hF, 3);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick(4'hF, 1'b0);
            if (c == 5) chk("rst_hold_e5", 32'(bus.inport), 32'h00);
        end
        chk("rst_hold_e6", 32'(bus.inport), 32'hFF);
        chk("rst_hold_irq", 32'(bus.irq), 32'h1);
        tick(4'hF, 1'b1);
        chk("rst_hold_clr", 32'(bus.inport), 32'hF0);
        ticks(4'h0, 8);
        chk("idle", 32'(bus.inport), 32'h00);

        // Clean press on button 0, then read.
        for (int c = 1; c <= 6; c++) begin
            tick(4'h1, 1'b0);
            if (c == 5) chk("press_e5", 32'(bus.inport), 32'h00);
        end
        chk("press_e6", 32'(bus.inport), 32'h11);
        tick(4'h1, 1'b1);
        chk("press_rd", 32'(bus.inport), 32'h10);
        chk("press_rd_irq", 32'(bus.irq), 32'h0);
        ticks(4'h0, 8);

        // Bouncing button 1 never settles.
        ticks(4'h2, 3);
        ticks(4'h0, 1);
        ticks(4'h2, 3);
        ticks(4'h0, 8);
        chk("bounce", 32'(bus.inport), 32'h00);

        // Second press of button 2 before any read.
        ticks(4'h4, 6);
        ticks(4'h0, 6);
        chk("rel_level", 32'(bus.inport), 32'h04);
        ticks(4'h4, 6);
        chk("ovr_set", 32'(bus.ovr), 32'h1);
        chk("ovr_pend", 32'(bus.inport), 32'h44);
        ticks(4'h0, 6);
        tick(4'h0, 1'b1);
        chk("ovr_rd", 32'(bus.inport), 32'h00);
        chk("ovr_clr", 32'(bus.ovr), 32'h0);

        // Read strobe on the very edge button 3 is accepted.
        ticks(4'h8, 5);
        tick(4'h8, 1'b1);
        chk("race_pend", 32'(bus.inport), 32'h88);
        chk("race_ovr", 32'(bus.ovr), 32'h0);
        ticks(4'h0, 6);
        tick(4'h0, 1'b1);

        // Reset in the middle of a debounce count.
        ticks(4'h1, 4);
        assert_reset();
        ticks(4'h1, 2);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick(4'h1, 1'b0);
            if (c == 5) chk("midrst_e5", 32'(bus.inport), 32'h00);
        end
        chk("midrst_e6", 32'(bus.inport), 32'h11);
        ticks(4'h0, 6);
        tick(4'h0, 1'b1);

        // Randomized: slowly changing pins, random strobes, occasional reset.
        begin
            logic [N-1:0] b;
            logic         rd;
            b = '0;
            for (int c = 0; c < 3000; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
                rd = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 399) == 0) begin
                    assert_reset();
                    tick(b, rd);
                    tick(b, rd);
                    rst_n = 1'b1;
                end else begin
                    tick(b, rd);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
